// File: rtl/tv_pkg.sv
// Shared types and vector-field helpers for the test-vector checker.
// Vector word layout is {stim, expected, care}, MSB first.
package tv_pkg;

    localparam int TV_MAXW = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_CHECK,
        S_DONE
    } tv_state_t;

    typedef logic [TV_MAXW-1:0] tv_word_t;

    function automatic tv_word_t tv_mask(int w);
        return (tv_word_t'(1) << w) - tv_word_t'(1);
    endfunction

    function automatic tv_word_t tv_care(tv_word_t v, int n_out);
        return v & tv_mask(n_out);
    endfunction

    function automatic tv_word_t tv_expected(tv_word_t v, int n_out);
        return (v >> n_out) & tv_mask(n_out);
    endfunction

    function automatic tv_word_t tv_stim(tv_word_t v, int n_in, int n_out);
        return (v >> (2 * n_out)) & tv_mask(n_in);
    endfunction

endpackage

// File: rtl/tv_mem.sv
// Vector store: single write port, registered synchronous read.
// The read register doubles as the stimulus/expected/care holding register.
module tv_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int VW    = 6
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [VW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [VW-1:0] rdata
);

    logic [VW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rdata <= '0;
        else if (re)  rdata <= mem[raddr];
    end

endmodule

// File: rtl/tv_checker.sv
// Self-checking test-vector engine: applies stored vectors to a
// combinational block, waits SETTLE cycles, checks with care masking.
module tv_checker
    import tv_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int N_OUT  = 1,
    parameter int DEPTH  = 16,
    parameter int SETTLE = 1,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1),
    localparam int VW = N_IN + 2 * N_OUT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CW-1:0]    num_vec,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [VW-1:0]    wr_data,
    output logic [N_IN-1:0]  dut_in,
    input  logic [N_OUT-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CW-1:0]    err_count,
    output logic [CW-1:0]    vec_count,
    output logic             err_pulse,
    output logic [AW-1:0]    err_index,
    output logic [AW-1:0]    first_err
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    tv_state_t        state;
    logic [AW-1:0]    idx;
    logic [CW-1:0]    n;
    logic [SW-1:0]    wcnt;
    logic [VW-1:0]    rd_q;
    logic [N_OUT-1:0] expv;
    logic [N_OUT-1:0] care;
    logic [CW-1:0]    n_req;
    logic             mismatch;
    logic             last;
    logic             wr_ok;
    logic             rd_en;

    assign wr_ok = wr_en && !busy;
    assign rd_en = (state == S_FETCH) && !abort;

    tv_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .VW    (VW)
    ) u_mem (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (wr_ok),
        .waddr   (wr_addr),
        .wdata   (wr_data),
        .re      (rd_en),
        .raddr   (idx),
        .rdata   (rd_q)
    );

    assign dut_in = N_IN'(tv_stim(TV_MAXW'(rd_q), N_IN, N_OUT));
    assign expv   = N_OUT'(tv_expected(TV_MAXW'(rd_q), N_OUT));
    assign care   = N_OUT'(tv_care(TV_MAXW'(rd_q), N_OUT));

    assign mismatch = |((dut_out ^ expv) & care);
    assign last     = (CW'(idx) + CW'(1)) == n;
    assign n_req    = (num_vec > CW'(DEPTH)) ? CW'(DEPTH) : num_vec;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            n         <= '0;
            wcnt      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            vec_count <= '0;
            err_pulse <= 1'b0;
            err_index <= '0;
            first_err <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (abort) begin
                state <= S_IDLE;
                busy  <= 1'b0;
                done  <= 1'b0;
                pass  <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            err_count <= '0;
                            vec_count <= '0;
                            first_err <= '0;
                            idx       <= '0;
                            n         <= n_req;
                            if (n_req == '0) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                                pass  <= 1'b1;
                            end else begin
                                state <= S_FETCH;
                                busy  <= 1'b1;
                                done  <= 1'b0;
                                pass  <= 1'b0;
                            end
                        end
                    end
                    S_FETCH: begin
                        state <= S_WAIT;
                        wcnt  <= '0;
                    end
                    S_WAIT: begin
                        if (wcnt == SW'(SETTLE - 1)) state <= S_CHECK;
                        else                         wcnt  <= wcnt + SW'(1);
                    end
                    S_CHECK: begin
                        vec_count <= vec_count + CW'(1);
                        if (mismatch) begin
                            err_count <= err_count + CW'(1);
                            err_pulse <= 1'b1;
                            err_index <= idx;
                            if (err_count == '0) first_err <= idx;
                        end
                        if (last) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_count == '0) && !mismatch;
                        end else begin
                            idx   <= idx + AW'(1);
                            state <= S_FETCH;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tv_checker.sv
// Bench for tv_checker: directed truth-table runs plus randomized runs,
// all outputs compared every cycle against a timing-arithmetic model.
module tb_tv_checker;

    localparam int N_IN   = 4;
    localparam int N_OUT  = 1;
    localparam int DEPTH  = 16;
    localparam int SETTLE = 1;
    localparam int P      = SETTLE + 2;
    localparam int AW     = 4;
    localparam int CW     = 5;
    localparam int VW     = 6;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [CW-1:0]    num_vec = '0;
    logic             wr_en = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic [VW-1:0]    wr_data = '0;
    logic [N_IN-1:0]  dut_in;
    logic [N_OUT-1:0] dut_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CW-1:0]    err_count;
    logic [CW-1:0]    vec_count;
    logic             err_pulse;
    logic [AW-1:0]    err_index;
    logic [AW-1:0]    first_err;

    always #5 clk = ~clk;

    tv_checker #(
        .N_IN   (N_IN),
        .N_OUT  (N_OUT),
        .DEPTH  (DEPTH),
        .SETTLE (SETTLE)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .abort     (abort),
        .num_vec   (num_vec),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .dut_in    (dut_in),
        .dut_out   (dut_out),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .vec_count (vec_count),
        .err_pulse (err_pulse),
        .err_index (err_index),
        .first_err (first_err)
    );

    // block under test: selectable behaviour
    int        mode = 0;
    bit [15:0] rtab = '0;

    function automatic bit f_ok(logic [3:0] v);
        bit a, b, c, d;
        {a, b, c, d} = v;
        return (b & d) | (a & ~d) | (a & c);
    endfunction

    function automatic bit dutf(logic [3:0] v, int md);
        case (md)
            0:       return f_ok(v);
            1:       return 1'b0;
            2:       return (v == 4'd0) ? 1'b1 : f_ok(v);
            default: return rtab[v];
        endcase
    endfunction

    assign dut_out = dutf(dut_in, mode);

    typedef struct {
        int din;
        bit busy;
        bit done;
        bit pass;
        bit pulse;
        int errs;
        int vcnt;
        int eidx;
        int ferr;
    } exp_t;

    bit [3:0] m_stim [16];
    bit       m_exp  [16];
    bit       m_care [16];
    bit [3:0] r_stim [16];
    bit       r_mis  [16];
    int       rn = 0;
    int       t0 = 0;
    bit       run_active = 1'b0;
    exp_t     snap;
    int       cyc = 0;
    int       checks = 0;
    int       fails = 0;
    int       pcount = 0;

    function automatic exp_t zero_exp();
        exp_t z;
        z.din = 0; z.busy = 0; z.done = 0; z.pass = 0; z.pulse = 0;
        z.errs = 0; z.vcnt = 0; z.eidx = 0; z.ferr = 0;
        return z;
    endfunction

    // outputs of a run as a function of cycles elapsed since start
    function automatic exp_t model_at(int cy);
        exp_t e;
        int c, k, ld, j;
        if (!run_active || (cy - t0) < 1) return snap;
        c = cy - t0;
        e = zero_exp();
        k = (c - 1) / P;
        if (k > rn) k = rn;
        for (int i = 0; i < k; i++) begin
            if (r_mis[i]) begin
                if (e.errs == 0) e.ferr = i;
                e.errs++;
            end
        end
        e.vcnt = k;
        e.busy = (c <= rn * P);
        e.done = (c > rn * P);
        e.pass = e.done && (e.errs == 0);
        j = (c - 1) / P;
        if ((c - 1) % P == 0 && j >= 1 && j <= rn && r_mis[j-1]) begin
            e.pulse = 1'b1;
            e.eidx  = j - 1;
        end
        ld = (c >= 2) ? (c - 2) / P + 1 : 0;
        if (ld > rn) ld = rn;
        e.din = (ld > 0) ? int'(r_stim[ld-1]) : snap.din;
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] act, int expv);
        checks++;
        if (act !== 32'(expv)) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, expv, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    exp_t ce;
    always @(negedge clk) begin
        ce = model_at(cyc);
        chk("dut_in", 32'(dut_in), ce.din);
        chk("busy", 32'(busy), int'(ce.busy));
        chk("done", 32'(done), int'(ce.done));
        chk("pass", 32'(pass), int'(ce.pass));
        chk("err_count", 32'(err_count), ce.errs);
        chk("vec_count", 32'(vec_count), ce.vcnt);
        chk("err_pulse", 32'(err_pulse), int'(ce.pulse));
        chk("first_err", 32'(first_err), ce.ferr);
        if (ce.pulse) chk("err_index", 32'(err_index), ce.eidx);
        if (err_pulse === 1'b1) pcount++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(int a, logic [VW-1:0] d);
        exp_t cur;
        cur = model_at(cyc);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        if (!cur.busy) begin
            m_stim[a] = d[5:2];
            m_exp[a]  = d[1];
            m_care[a] = d[0];
        end
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_start(int nv);
        exp_t cur;
        cur = model_at(cyc);
        if (!cur.busy) begin
            snap = cur;
            rn = (nv > DEPTH) ? DEPTH : nv;
            for (int i = 0; i < 16; i++) begin
                r_stim[i] = m_stim[i];
                r_mis[i]  = (dutf(m_stim[i], mode) ^ m_exp[i]) & m_care[i];
            end
            t0 = cyc;
            run_active = 1'b1;
        end
        start   = 1'b1;
        num_vec = CW'(nv);
        tick();
        start = 1'b0;
    endtask

    task automatic do_abort(bit with_start, int nv);
        exp_t cur;
        cur = model_at(cyc);
        abort   = 1'b1;
        start   = with_start;
        num_vec = CW'(nv);
        tick();
        abort = 1'b0;
        start = 1'b0;
        snap = cur;
        snap.busy = 0;
        snap.done = 0;
        snap.pass = 0;
        snap.pulse = 0;
        run_active = 1'b0;
    endtask

    task automatic wait_done(int limit, string name);
        int g;
        g = 0;
        while (done !== 1'b1 && g < limit) begin
            tick();
            g++;
        end
        chk(name, 32'(done), 1);
    endtask

    function automatic bit tt_care(int v);
        return !(v inside {0, 1, 2, 5, 7, 10, 14});
    endfunction

    task automatic load_tt();
        logic [3:0] s;
        for (int v = 0; v < 16; v++) begin
            s = 4'(v);
            wr(v, {s, f_ok(s), tt_care(v)});
        end
    endtask

    int bc;
    int g;
    int r;
    bit aborted;

    initial begin
        snap = zero_exp();
        mode = 0;
        #1;
        chk("reset_busy", 32'(busy), 0);
        chk("reset_dut_in", 32'(dut_in), 0);
        repeat (3) tick();
        reset_n = 1'b1;
        chk("reset_done", 32'(done), 0);
        chk("reset_err_count", 32'(err_count), 0);
        load_tt();

        // correct block: 16 vectors, 48 busy cycles
        mode = 0;
        do_start(16);
        bc = 0;
        g = 0;
        while (done !== 1'b1 && g < 200) begin
            if (busy === 1'b1) bc++;
            tick();
            g++;
        end
        chk("tt_busy_cycles", 32'(bc), 48);
        chk("tt_pass", 32'(pass), 1);
        chk("tt_err_count", 32'(err_count), 0);
        chk("tt_vec_count", 32'(vec_count), 16);

        // stuck-at-0 block
        mode = 1;
        pcount = 0;
        do_start(16);
        wait_done(200, "zero_done");
        tick();
        chk("zero_err_count", 32'(err_count), 5);
        chk("zero_first_err", 32'(first_err), 8);
        chk("zero_pulses", 32'(pcount), 5);
        chk("zero_pass", 32'(pass), 0);

        // mismatch only on a don't-care row
        mode = 2;
        do_start(16);
        wait_done(200, "dc_done");
        chk("dc_pass", 32'(pass), 1);

        // empty and oversized runs
        mode = 0;
        do_start(0);
        chk("n0_done", 32'(done), 1);
        chk("n0_pass", 32'(pass), 1);
        chk("n0_busy", 32'(busy), 0);
        do_start(20);
        wait_done(200, "n20_done");
        chk("n20_vec_count", 32'(vec_count), 16);

        // start/write while busy ignored, abort at vector 5
        do_start(16);
        do_start(2);
        wr(15, 6'b000000);
        g = 0;
        while (cyc - t0 < 5 * P + 1 && g < 100) begin
            tick();
            g++;
        end
        do_abort(1'b0, 0);
        chk("abort_vec_count", 32'(vec_count), 5);
        chk("abort_done", 32'(done), 0);
        chk("abort_busy", 32'(busy), 0);
        do_start(16);
        wait_done(200, "after_abort_done");
        chk("after_abort_pass", 32'(pass), 1);

        // asynchronous reset during vector 3
        mode = 1;
        do_start(16);
        g = 0;
        while (cyc - t0 < 3 * P + 2 && g < 100) begin
            tick();
            g++;
        end
        #2;
        reset_n = 1'b0;
        run_active = 1'b0;
        snap = zero_exp();
        #1;
        chk("rst_dut_in", 32'(dut_in), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_vec_count", 32'(vec_count), 0);
        chk("rst_err_count", 32'(err_count), 0);
        chk("rst_first_err", 32'(first_err), 0);
        tick();
        tick();
        reset_n = 1'b1;
        pcount = 0;
        do_start(16);
        wait_done(200, "post_rst_done");
        tick();
        chk("post_rst_err_count", 32'(err_count), 5);
        chk("post_rst_pulses", 32'(pcount), 5);

        // randomized runs
        for (int it = 0; it < 25; it++) begin
            for (int a = 0; a < 16; a++) wr(a, VW'($urandom));
            mode = 3;
            rtab = 16'($urandom);
            do_start($urandom_range(0, 20));
            aborted = 1'b0;
            g = 0;
            while (model_at(cyc).busy && g < 500) begin
                r = $urandom_range(0, 99);
                if (r < 3) begin
                    do_abort(r == 0, $urandom_range(0, 20));
                    aborted = 1'b1;
                end else if (r < 8) begin
                    do_start($urandom_range(0, 20));
                end else if (r < 12) begin
                    wr($urandom_range(0, 15), VW'($urandom));
                end else begin
                    tick();
                end
                g++;
            end
            if (!aborted) begin
                wait_done(50, "rand_done");
                if ($urandom_range(0, 3) == 0) do_abort(1'b0, 0);
            end
            tick();
        end

        tick();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/tv_checker.md
# tv_checker

Parametrised, self-checking test-vector engine that applies stored input vectors to a combinational block under test, waits a settle period, and compares the block's response against expected values with per-bit don't-care masking. It is the hardware successor of our file-driven truth-table benches: vectors are written through a load port, a run is launched with `start`, and error count, first failing index and pass/fail are reported on-chip. It sits beside any small combinational unit (truth-table or logic-minimisation exercises) in FPGA bring-up builds.

## Interface
- `N_IN`, 4, width of stimulus applied to the block under test
- `N_OUT`, 1, width of the response checked
- `DEPTH`, 16, number of vector slots (power of two, ≥2)
- `SETTLE`, 1, wait cycles between applying a vector and checking it (≥1)
- Derived: `AW = $clog2(DEPTH)`, `CW = $clog2(DEPTH+1)`, `VW = N_IN + 2*N_OUT`

- `clk` in 1: single clock, all logic on rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `start` in 1: single-cycle run request
- `abort` in 1: stop current run, return to IDLE
- `num_vec` in CW: vectors to run, sampled on accepted `start`
- `wr_en` in 1: vector memory write strobe
- `wr_addr` in AW: vector slot
- `wr_data` in VW: `{stim[N_IN], expected[N_OUT], care[N_OUT]}`, MSB first
- `dut_in` out N_IN: stimulus to block under test (registered)
- `dut_out` in N_OUT: response from block under test
- `busy` out 1: run in progress
- `done` out 1: run finished, held until next accepted `start` or `abort`
- `pass` out 1: valid while `done`; 1 iff `err_count == 0`
- `err_count` out CW: mismatching vectors this run
- `vec_count` out CW: vectors checked this run
- `err_pulse` out 1: one-cycle strobe on each mismatch
- `err_index` out AW: index of the mismatching vector, valid with `err_pulse`
- `first_err` out AW: index of first mismatch of the run, held

## Operation
- States: IDLE, FETCH, WAIT, CHECK, DONE.
- IDLE/DONE + `start`: clear `err_count`, `vec_count`, `first_err`, `done`, `pass`; latch `n = min(num_vec, DEPTH)`; if `n == 0` go to DONE with `pass=1`, else FETCH at index 0.
- FETCH (1 cycle): synchronous memory read; at end, `dut_in`, expected and care registers load.
- WAIT: `SETTLE` cycles; `dut_in` stable.
- CHECK (1 cycle): `mismatch = |((dut_out ^ expected) & care)`; care bit 0 means don't-care. At end: `vec_count++`; on mismatch `err_count++`, `err_pulse=1`, `err_index=idx`, `first_err=idx` if first. Then FETCH `idx+1`, or DONE if `idx+1 == n`.
- `busy` = state ∈ {FETCH, WAIT, CHECK}.
- `start` while busy: ignored. `wr_en` while busy: ignored (memory unchanged). `wr_en` in IDLE/DONE: writes slot.
- `abort` (any state) takes priority over `start` in the same cycle: to IDLE, `done=0`, counters hold last values.
- `dut_in` holds last vector after run; counters never wrap (CW covers DEPTH).

## Timing
- Reset: state IDLE; `dut_in`, `busy`, `done`, `pass`, `err_count`, `vec_count`, `err_pulse`, `err_index`, `first_err` all 0. Memory contents not reset.
- Reset asserted mid-run: immediate return to IDLE with the values above.
- Per vector: `SETTLE + 2` cycles. Run of n vectors: `busy` high for `n*(SETTLE+2)` cycles starting the cycle after `start`; `done` rises the cycle after the last CHECK.
- `err_pulse`/`err_index` registered, visible the cycle after CHECK.

## Structure
- Package `tv_pkg`: state enum `tv_state_t`, field-slicing functions for `{stim, expected, care}`.
- Sub-module `tv_mem`: DEPTH×VW single-port-write, synchronous-read RAM.

## Test plan
- Load 16 vectors for y = b&d | a&~d | a&c over abcd, care=0 on 0000,0001,0010,0101,0111,1010,1110; correct DUT, `num_vec=16` -> `done` after 48 cycles (SETTLE=1), `pass=1`, `err_count=0`, `vec_count=16`.
- Same vectors, DUT with y forced 0 -> `err_count=5` (1000,1011,1100,1101,1111), `first_err=8`, five `err_pulse`s.
- Don't-care check: DUT y=1 on 0000 only, otherwise correct -> `pass=1`.
- `num_vec=0` -> `done=1`, `pass=1` next cycle, `busy` never high; `num_vec=20` -> clamped, `vec_count=16`.
- `start` and `wr_en` during busy ignored; `abort` at vector 5 -> IDLE, `vec_count=5`, `done=0`.
- `reset_n` low at vector 3 -> all outputs 0 asynchronously; new `start` runs from index 0.
